// File: rtl/if_stage_pkg.sv
// ============================================================================
// if_stage_pkg : shared widths, NOP encoding and IF-stage state/select types
// Revision     : 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int WORD_ADDR_BUS = 30;
    localparam int WORD_DATA_BUS = 32;

    localparam logic [WORD_DATA_BUS-1:0] ISA_NOP = 32'h0;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    // What the IF pipeline register captures on the next edge.
    typedef enum logic [1:0] {
        IFR_KEEP   = 2'd0,
        IFR_BUS    = 2'd1,
        IFR_SKID   = 2'd2,
        IFR_BUBBLE = 2'd3
    } if_reg_sel_e;

endpackage

`default_nettype wire

// File: rtl/if_reg.sv
// ============================================================================
// if_reg   : IF pipeline register (load/hold/bubble) plus one-word skid buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_reg
    import if_stage_pkg::*;
#(
    parameter int ADDR_W = WORD_ADDR_BUS,
    parameter int DATA_W = WORD_DATA_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  if_reg_sel_e       sel,
    input  logic              skid_load,
    input  logic [ADDR_W-1:0] bus_pc,
    input  logic [DATA_W-1:0] bus_data,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en
);

    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_insn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc   <= '0;
            skid_insn <= '0;
        end else if (skid_load) begin
            skid_pc   <= bus_pc;
            skid_insn <= bus_data;
        end
    end

    // A bubble keeps the old PC so decode always sees a meaningful IFPC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc   <= '0;
            if_insn <= DATA_W'(ISA_NOP);
            if_en   <= 1'b0;
        end else begin
            case (sel)
                IFR_BUS: begin
                    if_pc   <= bus_pc;
                    if_insn <= bus_data;
                    if_en   <= 1'b1;
                end
                IFR_SKID: begin
                    if_pc   <= skid_pc;
                    if_insn <= skid_insn;
                    if_en   <= 1'b1;
                end
                IFR_BUBBLE: begin
                    if_insn <= DATA_W'(ISA_NOP);
                    if_en   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : instruction fetch - PC, fetch FSM and request/ready bus master
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W       = WORD_ADDR_BUS,
    parameter int                DATA_W       = WORD_DATA_BUS,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] NewPC,
    input  logic              BrTaken,
    input  logic [ADDR_W-1:0] BrAddr,
    output logic              BusReq,
    output logic [ADDR_W-1:0] BusAddr,
    input  logic [DATA_W-1:0] BusRdData,
    input  logic              BusRdy,
    output logic [ADDR_W-1:0] IFPC,
    output logic [DATA_W-1:0] IFInsn,
    output logic              IFEn
);

    if_state_e         state;
    if_state_e         next_state;
    if_reg_sel_e       sel;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] old_addr;
    logic              skid_load;
    logic              pc_inc;
    logic              old_load;
    logic              redirect;
    logic [ADDR_W-1:0] target;

    assign redirect = Flush || (BrTaken && !Stall);
    assign target   = Flush ? NewPC : BrAddr;

    // Bus side depends only on registered state; reset forces a cancel.
    assign BusReq  = !reset_ && (state != IF_HOLD);
    assign BusAddr = (state == IF_DRAIN) ? old_addr : pc;

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state    <= IF_FETCH;
            pc       <= RESET_VECTOR;
            old_addr <= '0;
        end else begin
            state <= next_state;
            if (redirect) begin
                pc <= target;
            end else if (pc_inc) begin
                pc <= pc + 1'b1;
            end
            if (old_load) begin
                old_addr <= pc;
            end
        end
    end

    always_comb begin
        next_state = state;
        sel        = IFR_KEEP;
        skid_load  = 1'b0;
        pc_inc     = 1'b0;
        old_load   = 1'b0;
        if (redirect) begin
            sel = IFR_BUBBLE;
            case (state)
                IF_FETCH: begin
                    // An outstanding request cannot be withdrawn; drain it.
                    if (!BusRdy) begin
                        old_load   = 1'b1;
                        next_state = IF_DRAIN;
                    end
                end
                IF_HOLD:  next_state = IF_FETCH;
                IF_DRAIN: if (BusRdy) next_state = IF_FETCH;
                default:  next_state = IF_FETCH;
            endcase
        end else if (Stall) begin
            case (state)
                IF_FETCH: begin
                    if (BusRdy) begin
                        skid_load  = 1'b1;
                        pc_inc     = 1'b1;
                        next_state = IF_HOLD;
                    end
                end
                IF_HOLD:  next_state = IF_HOLD;
                IF_DRAIN: if (BusRdy) next_state = IF_FETCH;
                default:  next_state = IF_FETCH;
            endcase
        end else begin
            case (state)
                IF_FETCH: begin
                    if (BusRdy) begin
                        sel    = IFR_BUS;
                        pc_inc = 1'b1;
                    end else begin
                        sel = IFR_BUBBLE;
                    end
                end
                IF_HOLD: begin
                    sel        = IFR_SKID;
                    next_state = IF_FETCH;
                end
                IF_DRAIN: begin
                    sel = IFR_BUBBLE;
                    if (BusRdy) next_state = IF_FETCH;
                end
                default: next_state = IF_FETCH;
            endcase
        end
    end

    if_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_reg (
        .clk       (clk),
        .rst       (reset_),
        .sel       (sel),
        .skid_load (skid_load),
        .bus_pc    (pc),
        .bus_data  (BusRdData),
        .if_pc     (IFPC),
        .if_insn   (IFInsn),
        .if_en     (IFEn)
    );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : directed scenarios plus randomized traffic against a queue model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        reset_;
    logic        Stall;
    logic        Flush;
    logic [29:0] NewPC;
    logic        BrTaken;
    logic [29:0] BrAddr;
    logic        BusReq;
    logic [29:0] BusAddr;
    logic [31:0] BusRdData;
    logic        BusRdy;
    logic [29:0] IFPC;
    logic [31:0] IFInsn;
    logic        IFEn;

    if_stage #(
        .ADDR_W       (30),
        .DATA_W       (32),
        .RESET_VECTOR (30'h0)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .Stall     (Stall),
        .Flush     (Flush),
        .NewPC     (NewPC),
        .BrTaken   (BrTaken),
        .BrAddr    (BrAddr),
        .BusReq    (BusReq),
        .BusAddr   (BusAddr),
        .BusRdData (BusRdData),
        .BusRdy    (BusRdy),
        .IFPC      (IFPC),
        .IFInsn    (IFInsn),
        .IFEn      (IFEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] insn;
    } word_t;

    // Reference model: architectural view of fetch progress.
    logic [29:0] m_pc;
    word_t       skid_q[$];
    logic        m_discard;
    logic [29:0] m_discard_addr;
    logic [29:0] m_ifpc;
    logic [31:0] m_ifinsn;
    logic        m_ifen;

    logic        exp_req;
    logic [29:0] exp_addr;
    logic        obs_req;
    logic [29:0] obs_addr;
    logic [31:0] data_mask;

    task automatic model_reset();
        m_pc      = 30'h0;
        skid_q.delete();
        m_discard = 1'b0;
        m_discard_addr = 30'h0;
        m_ifpc    = 30'h0;
        m_ifinsn  = 32'h0;
        m_ifen    = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic [29:0] np,
                              input logic br, input logic [29:0] ba,
                              input logic rdy, input logic [31:0] d);
        word_t w;
        if (fl || (br && !st)) begin
            if (skid_q.size() != 0) begin
                skid_q.delete();
            end else if (m_discard) begin
                if (rdy) m_discard = 1'b0;
            end else if (!rdy) begin
                m_discard      = 1'b1;
                m_discard_addr = m_pc;
            end
            m_pc     = fl ? np : ba;
            m_ifen   = 1'b0;
            m_ifinsn = 32'h0;
        end else if (st) begin
            if (skid_q.size() == 0) begin
                if (m_discard) begin
                    if (rdy) m_discard = 1'b0;
                end else if (rdy) begin
                    w.pc   = m_pc;
                    w.insn = d;
                    skid_q.push_back(w);
                    m_pc = m_pc + 30'd1;
                end
            end
        end else begin
            if (skid_q.size() != 0) begin
                w        = skid_q.pop_front();
                m_ifpc   = w.pc;
                m_ifinsn = w.insn;
                m_ifen   = 1'b1;
            end else if (m_discard) begin
                m_ifen   = 1'b0;
                m_ifinsn = 32'h0;
                if (rdy) m_discard = 1'b0;
            end else if (rdy) begin
                m_ifpc   = m_pc;
                m_ifinsn = d;
                m_ifen   = 1'b1;
                m_pc     = m_pc + 30'd1;
            end else begin
                m_ifen   = 1'b0;
                m_ifinsn = 32'h0;
            end
        end
    endtask

    // One cycle: drive after negedge, sample bus, clock, advance model, return at negedge.
    task automatic step(input logic st, input logic fl, input logic [29:0] np,
                        input logic br, input logic [29:0] ba, input logic rdy);
        Stall    = st;
        Flush    = fl;
        NewPC    = np;
        BrTaken  = br;
        BrAddr   = ba;
        BusRdy   = rdy;
        exp_req  = (skid_q.size() == 0);
        exp_addr = m_discard ? m_discard_addr : m_pc;
        BusRdData = {exp_addr, 2'b00} ^ data_mask;
        #1;
        obs_req  = BusReq;
        obs_addr = BusAddr;
        @(posedge clk);
        model_edge(st, fl, np, br, ba, rdy, BusRdData);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_ = 1'b1;
        Stall = 0; Flush = 0; NewPC = 0; BrTaken = 0; BrAddr = 0;
        BusRdy = 1'b1; BusRdData = 32'hDEAD_BEEF; data_mask = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (BusReq !== 1'b0) begin
            n_bad++; $display("FAIL reset_busreq: got %b want 0", BusReq);
        end
        n_cmp++;
        if (IFPC !== 30'h0 || IFInsn !== 32'h0 || IFEn !== 1'b0) begin
            n_bad++; $display("FAIL reset_ifreg: got pc=%h insn=%h en=%b want 0/0/0", IFPC, IFInsn, IFEn);
        end
        reset_ = 1'b0;
        #1;
        n_cmp++;
        if (IFEn !== 1'b0 || BusReq !== 1'b1 || BusAddr !== 30'h0) begin
            n_bad++; $display("FAIL post_reset: got en=%b req=%b addr=%h want 0/1/0", IFEn, BusReq, BusAddr);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            n_cmp++;
            if (IFPC !== 30'(i) || IFEn !== 1'b1 || IFInsn !== 32'(i * 4)) begin
                n_bad++; $display("FAIL seq_%0d: got pc=%h insn=%h en=%b want pc=%h insn=%h en=1",
                                  i, IFPC, IFInsn, IFEn, 30'(i), 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (IFPC !== 30'd4 || IFEn !== 1'b1) begin
            n_bad++; $display("FAIL stall_pre: got pc=%h en=%b want 4/1", IFPC, IFEn);
        end
        step(1, 0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_addr !== 30'd5 || IFPC !== 30'd4 || IFEn !== 1'b1 || IFInsn !== 32'd16) begin
            n_bad++; $display("FAIL stall_capture: got addr=%h pc=%h insn=%h en=%b want 5/4/10/1",
                              obs_addr, IFPC, IFInsn, IFEn);
        end
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0, 1);
            n_cmp++;
            if (obs_req !== 1'b0 || IFPC !== 30'd4 || IFEn !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold_%0d: got req=%b pc=%h en=%b want 0/4/1", i, obs_req, IFPC, IFEn);
            end
        end
        step(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_req !== 1'b0 || IFPC !== 30'd5 || IFEn !== 1'b1 || IFInsn !== 32'd20) begin
            n_bad++; $display("FAIL stall_release: got req=%b pc=%h insn=%h en=%b want 0/5/14/1",
                              obs_req, IFPC, IFInsn, IFEn);
        end
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_addr !== 30'd6 || IFPC !== 30'd6 || IFEn !== 1'b1) begin
            n_bad++; $display("FAIL stall_resume: got addr=%h pc=%h en=%b want 6/6/1", obs_addr, IFPC, IFEn);
        end
    endtask

    task automatic test_branch();
        step(0, 0, 0, 1, 30'h100, 1);
        n_cmp++;
        if (obs_addr !== 30'd7 || IFEn !== 1'b0 || IFInsn !== 32'h0 || IFPC !== 30'd6) begin
            n_bad++; $display("FAIL branch_bubble: got addr=%h pc=%h insn=%h en=%b want 7/6/0/0",
                              obs_addr, IFPC, IFInsn, IFEn);
        end
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_addr !== 30'h100 || IFPC !== 30'h100 || IFEn !== 1'b1 || IFInsn !== 32'h400) begin
            n_bad++; $display("FAIL branch_target: got addr=%h pc=%h insn=%h en=%b want 100/100/400/1",
                              obs_addr, IFPC, IFInsn, IFEn);
        end
    endtask

    task automatic test_flush_drain();
        step(0, 0, 0, 1, 30'h10, 1);
        step(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_addr !== 30'h10 || IFEn !== 1'b0) begin
            n_bad++; $display("FAIL drain_wait: got addr=%h en=%b want 10/0", obs_addr, IFEn);
        end
        step(0, 1, 30'h40, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (obs_req !== 1'b1 || obs_addr !== 30'h10 || IFEn !== 1'b0) begin
                n_bad++; $display("FAIL drain_hold_%0d: got req=%b addr=%h en=%b want 1/10/0", i, obs_req, obs_addr, IFEn);
            end
        end
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_addr !== 30'h10 || IFEn !== 1'b0) begin
            n_bad++; $display("FAIL drain_done: got addr=%h en=%b want 10/0", obs_addr, IFEn);
        end
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_addr !== 30'h40 || IFPC !== 30'h40 || IFEn !== 1'b1 || IFInsn !== 32'h100) begin
            n_bad++; $display("FAIL drain_target: got addr=%h pc=%h insn=%h en=%b want 40/40/100/1",
                              obs_addr, IFPC, IFInsn, IFEn);
        end
    endtask

    task automatic test_flush_and_branch();
        step(0, 1, 30'h200, 1, 30'h300, 1);
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_addr !== 30'h200 || IFPC !== 30'h200 || IFEn !== 1'b1) begin
            n_bad++; $display("FAIL flush_over_branch: got addr=%h pc=%h en=%b want 200/200/1", obs_addr, IFPC, IFEn);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 1, 30'h3FFFFFFF, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_addr !== 30'h0 || IFPC !== 30'h0 || IFEn !== 1'b1) begin
            n_bad++; $display("FAIL pc_wrap: got addr=%h pc=%h en=%b want 0/0/1", obs_addr, IFPC, IFEn);
        end
    endtask

    task automatic test_reset_mid();
        Stall = 0; Flush = 0; BrTaken = 0; BusRdy = 1'b0;
        #2 reset_ = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (BusReq !== 1'b0 || IFEn !== 1'b0 || IFPC !== 30'h0) begin
            n_bad++; $display("FAIL mid_reset: got req=%b en=%b pc=%h want 0/0/0", BusReq, IFEn, IFPC);
        end
        @(negedge clk);
        reset_ = 1'b0;
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (obs_addr !== 30'h0 || IFPC !== 30'h0 || IFEn !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset_restart: got addr=%h pc=%h en=%b want 0/0/1", obs_addr, IFPC, IFEn);
        end
    endtask

    task automatic test_random(input int cycles);
        logic st, fl, br, rdy;
        logic [29:0] np, ba;
        for (int c = 0; c < cycles; c++) begin
            st  = ($urandom_range(99) < 30);
            fl  = ($urandom_range(99) < 6);
            br  = ($urandom_range(99) < 10);
            rdy = ($urandom_range(99) < 60);
            np  = 30'($urandom);
            ba  = 30'($urandom);
            data_mask = $urandom;
            step(st, fl, np, br, ba, rdy);
            n_cmp++;
            if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr) ||
                IFPC !== m_ifpc || IFInsn !== m_ifinsn || IFEn !== m_ifen) begin
                n_bad++;
                $display("FAIL random_%0d: got req=%b addr=%h pc=%h insn=%h en=%b want req=%b addr=%h pc=%h insn=%h en=%b",
                         c, obs_req, obs_addr, IFPC, IFInsn, IFEn,
                         exp_req, exp_addr, m_ifpc, m_ifinsn, m_ifen);
            end
        end
        data_mask = 32'h0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush_drain();
        test_flush_and_branch();
        test_wrap();
        test_random(600);
        test_reset_mid();
        test_random(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
